ls191a_updown_counter: RTL and testbench

- Presettable synchronous up/down binary counter. It is the down-counting (reverse-direction) companion to the team's LS161-style up counter.
- Used for countdown timers, programmable dividers and position tracking.
- Cascadable through a trickle-enable input and a ripple-borrow/carry output, so N stages form a wider up/down counter on one clock.

---
 rtl/ls191a_updown_counter.sv | 96 +++++++++
 tb/tb_ls191a_updown_counter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ls191a_updown_counter.sv
// ----------------------------------------------------------------------------
// ls191a_updown_counter
//
// Presettable synchronous up/down binary counter in the style of the LS191.
// Stages cascade through ENT (trickle enable in) and RCO (ripple carry/borrow
// out) so that several counters on one clock behave as one wider counter.
// With RELOAD_EN set, the counter reloads the preset value at terminal count
// instead of wrapping, which turns it into a programmable divider.
//
// Parameters:
//   WIDTH      counter width in bits (>= 2)
//   RELOAD_EN  1 = reload D at terminal count, 0 = wrap modulo 2^WIDTH
//
// Ports:
//   CLK      in   rising-edge clock
//   CLR      in   asynchronous clear, active high
//   D        in   parallel preset value
//   LOAD_n   in   synchronous parallel load, active low (highest priority)
//   CTEN_n   in   local count enable, active low
//   ENT      in   trickle enable from the previous stage's RCO, active high
//   DU       in   direction: 0 = up, 1 = down
//   Q        out  counter value
//   MAX_MIN  out  terminal-count flag for the current direction
//   RCO      out  ripple carry/borrow to the next stage
//   WRAP     out  registered one-cycle pulse after a terminal-count event
// ----------------------------------------------------------------------------
module ls191a_updown_counter #(
    parameter int WIDTH     = 4,
    parameter bit RELOAD_EN = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_n,
    input  logic             CTEN_n,
    input  logic             ENT,
    input  logic             DU,
    output logic [WIDTH-1:0] Q,
    output logic             MAX_MIN,
    output logic             RCO,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    logic             count_en;
    logic             max_min;

    // Terminal count depends only on the value and the direction, so a change
    // of DU is reflected on MAX_MIN/RCO in the same cycle.
    always_comb begin
        count_en = ~CTEN_n & ENT;
        max_min  = DU ? (q_q == '0) : (q_q == ALL_ONES);
    end

    // Load is tested first and on its own so that unknown direction or enable
    // inputs cannot disturb the value being loaded.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (!LOAD_n) begin
            q_d = D;
        end else if (count_en) begin
            wrap_d = max_min;
            if (max_min && RELOAD_EN) begin
                q_d = D;
            end else if (DU) begin
                q_d = q_q - ONE;
            end else begin
                q_d = q_q + ONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q       = q_q;
    assign MAX_MIN = max_min;
    assign RCO     = max_min & count_en;
    assign WRAP    = wrap_q;

endmodule

// File: tb/tb_ls191a_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_ls191a_updown_counter
//
// Directed testbench for ls191a_updown_counter. Three arrangements share one
// clock and one clear: a plain 4-bit counter, a 4-bit counter in reload
// (divider) mode, and two 4-bit stages cascaded into an 8-bit counter.
// ----------------------------------------------------------------------------
module tb_ls191a_updown_counter;

    logic       clk;
    logic       clr;

    // plain counter
    logic [3:0] d;
    logic       load_n;
    logic       cten_n;
    logic       ent;
    logic       du;
    logic [3:0] q;
    logic       max_min;
    logic       rco;
    logic       wrap;

    // reload-mode counter
    logic [3:0] d_r;
    logic       load_n_r;
    logic       cten_n_r;
    logic       du_r;
    logic [3:0] q_r;
    logic       max_min_r;
    logic       rco_r;
    logic       wrap_r;

    // cascaded pair
    logic [7:0] d_c;
    logic       load_n_c;
    logic       cten_n_c;
    logic       du_c;
    logic [3:0] q_lo;
    logic [3:0] q_hi;
    logic       max_min_lo;
    logic       max_min_hi;
    logic       rco_lo;
    logic       rco_hi;
    logic       wrap_lo;
    logic       wrap_hi;

    int checks;
    int errors;

    ls191a_updown_counter #(.WIDTH(4), .RELOAD_EN(1'b0)) u_dut (
        .CLK(clk), .CLR(clr), .D(d), .LOAD_n(load_n), .CTEN_n(cten_n),
        .ENT(ent), .DU(du), .Q(q), .MAX_MIN(max_min), .RCO(rco), .WRAP(wrap)
    );

    ls191a_updown_counter #(.WIDTH(4), .RELOAD_EN(1'b1)) u_reload (
        .CLK(clk), .CLR(clr), .D(d_r), .LOAD_n(load_n_r), .CTEN_n(cten_n_r),
        .ENT(1'b1), .DU(du_r), .Q(q_r), .MAX_MIN(max_min_r), .RCO(rco_r),
        .WRAP(wrap_r)
    );

    ls191a_updown_counter #(.WIDTH(4), .RELOAD_EN(1'b0)) u_lo (
        .CLK(clk), .CLR(clr), .D(d_c[3:0]), .LOAD_n(load_n_c), .CTEN_n(cten_n_c),
        .ENT(1'b1), .DU(du_c), .Q(q_lo), .MAX_MIN(max_min_lo), .RCO(rco_lo),
        .WRAP(wrap_lo)
    );

    ls191a_updown_counter #(.WIDTH(4), .RELOAD_EN(1'b0)) u_hi (
        .CLK(clk), .CLR(clr), .D(d_c[7:4]), .LOAD_n(load_n_c), .CTEN_n(cten_n_c),
        .ENT(rco_lo), .DU(du_c), .Q(q_hi), .MAX_MIN(max_min_hi), .RCO(rco_hi),
        .WRAP(wrap_hi)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Drives the inputs of the plain counter.
    task automatic applyStimulus(input logic ld_n, input logic ct_n,
                                 input logic en_t, input logic dir,
                                 input logic [3:0] din);
        load_n = ld_n;
        cten_n = ct_n;
        ent    = en_t;
        du     = dir;
        d      = din;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_q;
        logic [3:0] prev_q;

        checks   = 0;
        errors   = 0;
        clr      = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        d_r      = 4'h0;
        load_n_r = 1'b1;
        cten_n_r = 1'b1;
        du_r     = 1'b0;
        d_c      = 8'h00;
        load_n_c = 1'b1;
        cten_n_c = 1'b1;
        du_c     = 1'b0;

        // Reset state, observed before any clock edge.
        #2 clr = 1'b1;
        #1;
        checkOutput("rst_q", q, 4'h0);
        checkOutput("rst_wrap", wrap, 1'b0);
        checkOutput("rst_maxmin_up", max_min, 1'b0);
        checkOutput("rst_rco", rco, 1'b0);
        @(posedge clk);
        #1 clr = 1'b0;

        // Load 9, then clear asynchronously while counting.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h9);
        tick();
        checkOutput("load9_q", q, 4'h9);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h9);
        #2 clr = 1'b1;
        #1;
        checkOutput("clr_q", q, 4'h0);
        checkOutput("clr_wrap", wrap, 1'b0);
        du = 1'b1;
        #1;
        checkOutput("clr_maxmin_down", max_min, 1'b1);
        checkOutput("clr_rco_down", rco, 1'b1);
        du = 1'b0;
        #1;
        checkOutput("clr_maxmin_up", max_min, 1'b0);
        @(posedge clk);
        #1 clr = 1'b0;

        // Load D and count down through zero to F.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hD);
        tick();
        checkOutput("loadD_q", q, 4'hD);
        checkOutput("loadD_wrap", wrap, 1'b0);
        checkOutput("loadD_maxmin", max_min, 1'b0);
        load_n = 1'b1;
        exp_q  = 4'hD;
        for (int i = 0; i < 14; i++) begin
            prev_q = exp_q;
            exp_q  = prev_q - 4'h1;
            tick();
            checkOutput("down_q", q, exp_q);
            checkOutput("down_wrap", wrap, prev_q == 4'h0);
            checkOutput("down_maxmin", max_min, exp_q == 4'h0);
            checkOutput("down_rco", rco, exp_q == 4'h0);
        end

        // Up count E, F, hold on ENT low, then wrap to 0.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'hE);
        tick();
        checkOutput("upE_q", q, 4'hE);
        checkOutput("upE_rco", rco, 1'b0);
        load_n = 1'b1;
        tick();
        checkOutput("upF_q", q, 4'hF);
        checkOutput("upF_rco", rco, 1'b1);
        checkOutput("upF_wrap", wrap, 1'b0);
        ent = 1'b0;
        #1;
        checkOutput("entlow_rco", rco, 1'b0);
        checkOutput("entlow_maxmin", max_min, 1'b1);
        tick();
        checkOutput("entlow_hold_q", q, 4'hF);
        checkOutput("entlow_wrap", wrap, 1'b0);
        ent = 1'b1;
        tick();
        checkOutput("upwrap_q", q, 4'h0);
        checkOutput("upwrap_wrap", wrap, 1'b1);

        // CTEN_n high holds the value.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        tick();
        checkOutput("hold_q", q, 4'h0);
        checkOutput("hold_wrap", wrap, 1'b0);

        // Load at terminal count (Q=0, down, enabled) overrides the wrap.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
        #1;
        checkOutput("preload_rco", rco, 1'b1);
        tick();
        checkOutput("loadterm_q", q, 4'h5);
        checkOutput("loadterm_wrap", wrap, 1'b0);
        load_n = 1'b1;

        // Reload mode: D=3 counting down divides by 4.
        d_r      = 4'h3;
        du_r     = 1'b1;
        cten_n_r = 1'b0;
        load_n_r = 1'b0;
        tick();
        checkOutput("rel_load_q", q_r, 4'h3);
        load_n_r = 1'b1;
        begin
            logic [3:0] rel_seq [8];
            logic       rel_wrap [8];
            rel_seq  = '{4'h2, 4'h1, 4'h0, 4'h3, 4'h2, 4'h1, 4'h0, 4'h3};
            rel_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 8; i++) begin
                tick();
                checkOutput("rel_q", q_r, rel_seq[i]);
                checkOutput("rel_wrap", wrap_r, rel_wrap[i]);
            end
        end
        cten_n_r = 1'b1;

        // Cascaded 8-bit down counter.
        du_c     = 1'b1;
        cten_n_c = 1'b0;
        d_c      = 8'h10;
        load_n_c = 1'b0;
        tick();
        checkOutput("cas_load10", {q_hi, q_lo}, 8'h10);
        load_n_c = 1'b1;
        tick();
        checkOutput("cas_0F", {q_hi, q_lo}, 8'h0F);
        tick();
        checkOutput("cas_0E", {q_hi, q_lo}, 8'h0E);
        d_c      = 8'h00;
        load_n_c = 1'b0;
        tick();
        checkOutput("cas_load00", {q_hi, q_lo}, 8'h00);
        checkOutput("cas_rco_hi", rco_hi, 1'b1);
        load_n_c = 1'b1;
        tick();
        checkOutput("cas_FF", {q_hi, q_lo}, 8'hFF);
        checkOutput("cas_wrap_hi", wrap_hi, 1'b1);
        tick();
        checkOutput("cas_FE", {q_hi, q_lo}, 8'hFE);
        checkOutput("cas_wrap_hi_clear", wrap_hi, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
